axi_mem_responder: RTL and testbench

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

---
 rtl/axi_mem_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave backed by a 2^ADDR_BITS x 64-bit register array.
// Independent write (AW/W/B) and read (AR/R) engines; every burst is treated as
// INCR of 8-byte beats that wrap modulo the memory depth.
// Optional macro AXI_MEM_RESP_ERR_EN: a burst whose start address is outside
// [BASE_ADDR, BASE_ADDR + 8<<ADDR_BITS) completes with SLVERR; its writes are
// dropped and its reads return zero.
module axi_mem_responder #(
  parameter int          ADDR_BITS = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        io_axi_aw_valid,
  output logic        io_axi_aw_ready,
  input  logic [31:0] io_axi_aw_bits_addr,
  input  logic [5:0]  io_axi_aw_bits_id,
  input  logic [7:0]  io_axi_aw_bits_len,
  input  logic [2:0]  io_axi_aw_bits_size,
  input  logic [1:0]  io_axi_aw_bits_burst,
  input  logic        io_axi_w_valid,
  output logic        io_axi_w_ready,
  input  logic [63:0] io_axi_w_bits_data,
  input  logic [7:0]  io_axi_w_bits_strb,
  input  logic        io_axi_w_bits_last,
  output logic        io_axi_b_valid,
  input  logic        io_axi_b_ready,
  output logic [5:0]  io_axi_b_bits_id,
  output logic [1:0]  io_axi_b_bits_resp,
  input  logic        io_axi_ar_valid,
  output logic        io_axi_ar_ready,
  input  logic [31:0] io_axi_ar_bits_addr,
  input  logic [5:0]  io_axi_ar_bits_id,
  input  logic [7:0]  io_axi_ar_bits_len,
  input  logic [2:0]  io_axi_ar_bits_size,
  input  logic [1:0]  io_axi_ar_bits_burst,
  output logic        io_axi_r_valid,
  input  logic        io_axi_r_ready,
  output logic [63:0] io_axi_r_bits_data,
  output logic [5:0]  io_axi_r_bits_id,
  output logic [1:0]  io_axi_r_bits_resp,
  output logic        io_axi_r_bits_last
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [63:0] mem_q [DEPTH];

  // Offsets from the window base; the word index is the low slice, the
  // upper bits only matter for the optional range check.
  logic [31:0]          aw_off, ar_off;
  logic [ADDR_BITS-1:0] aw_idx, ar_idx;
  logic                 aw_err, ar_err;

  assign aw_off = io_axi_aw_bits_addr - BASE_ADDR;
  assign ar_off = io_axi_ar_bits_addr - BASE_ADDR;
  assign aw_idx = aw_off[ADDR_BITS+2:3];
  assign ar_idx = ar_off[ADDR_BITS+2:3];

`ifdef AXI_MEM_RESP_ERR_EN
  // Unsigned wrap makes addresses below BASE_ADDR look huge, so one compare covers both sides.
  assign aw_err = (aw_off >> (ADDR_BITS + 3)) != 32'd0;
  assign ar_err = (ar_off >> (ADDR_BITS + 3)) != 32'd0;
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // size/burst/last are ignored by design; fold them away so they are visibly consumed.
  logic unused_sig;
  assign unused_sig = ^{io_axi_aw_bits_size, io_axi_aw_bits_burst, io_axi_ar_bits_size,
                        io_axi_ar_bits_burst, io_axi_w_bits_last, aw_off, ar_off};

  // Ready outputs stay low through reset and come up on the first edge after release.
  logic alive_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) alive_q <= 1'b0;
    else          alive_q <= 1'b1;

  // ---------------- write engine ----------------
  w_state_e             w_state_q, w_state_d;
  logic [5:0]           w_id_q, w_id_d;
  logic [ADDR_BITS-1:0] w_idx_q, w_idx_d;
  logic [7:0]           w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic                 w_err_q, w_err_d;
  logic                 mem_we;

  // Write FSM state and burst context registers.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end

  // Write FSM next state, handshake outputs and memory write enable.
  always_comb begin
    w_state_d       = w_state_q;
    w_id_d          = w_id_q;
    w_idx_d         = w_idx_q;
    w_len_d         = w_len_q;
    w_cnt_d         = w_cnt_q;
    w_err_d         = w_err_q;
    io_axi_aw_ready = 1'b0;
    io_axi_w_ready  = 1'b0;
    io_axi_b_valid  = 1'b0;
    mem_we          = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        io_axi_aw_ready = alive_q;
        if (alive_q && io_axi_aw_valid) begin
          w_id_d    = io_axi_aw_bits_id;
          w_idx_d   = aw_idx;
          w_len_d   = io_axi_aw_bits_len;
          w_cnt_d   = 8'd0;
          w_err_d   = aw_err;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        io_axi_w_ready = 1'b1;
        if (io_axi_w_valid) begin
          mem_we  = !w_err_q;
          w_idx_d = w_idx_q + ADDR_BITS'(1);
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
          else                    w_cnt_d   = w_cnt_q + 8'd1;
        end
      end
      W_RESP: begin
        io_axi_b_valid = 1'b1;
        if (io_axi_b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign io_axi_b_bits_id   = w_id_q;
  assign io_axi_b_bits_resp = {w_err_q, 1'b0};

  // Byte-strobed memory update; contents intentionally survive reset.
  always_ff @(posedge clock)
    if (mem_we)
      for (int b = 0; b < 8; b++)
        if (io_axi_w_bits_strb[b]) mem_q[w_idx_q][8*b +: 8] <= io_axi_w_bits_data[8*b +: 8];

  // ---------------- read engine ----------------
  r_state_e             r_state_q, r_state_d;
  logic [5:0]           r_id_q, r_id_d;
  logic [ADDR_BITS-1:0] r_idx_q, r_idx_d, r_idx_nx;
  logic [7:0]           r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic                 r_err_q, r_err_d;
  logic [63:0]          r_data_q, r_data_d;

  assign r_idx_nx = r_idx_q + ADDR_BITS'(1);

  // Read FSM state, burst context and the registered beat data.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_err_q   <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_err_q   <= r_err_d;
      r_data_q  <= r_data_d;
    end

  // Read FSM next state; memory is sampled before this edge's write lands,
  // so a same-cycle read of a word being written sees the old contents.
  always_comb begin
    r_state_d       = r_state_q;
    r_id_d          = r_id_q;
    r_idx_d         = r_idx_q;
    r_len_d         = r_len_q;
    r_cnt_d         = r_cnt_q;
    r_err_d         = r_err_q;
    r_data_d        = r_data_q;
    io_axi_ar_ready = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        io_axi_ar_ready = alive_q;
        if (alive_q && io_axi_ar_valid) begin
          r_id_d    = io_axi_ar_bits_id;
          r_idx_d   = ar_idx;
          r_len_d   = io_axi_ar_bits_len;
          r_cnt_d   = 8'd0;
          r_err_d   = ar_err;
          r_data_d  = ar_err ? 64'd0 : mem_q[ar_idx];
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (io_axi_r_ready) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d  = r_cnt_q + 8'd1;
            r_idx_d  = r_idx_nx;
            r_data_d = r_err_q ? 64'd0 : mem_q[r_idx_nx];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign io_axi_r_valid     = (r_state_q == R_DATA);
  assign io_axi_r_bits_last = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
  assign io_axi_r_bits_data = r_data_q;
  assign io_axi_r_bits_id   = r_id_q;
  assign io_axi_r_bits_resp = {r_err_q, 1'b0};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: single beats, strobes, bursts with
// steady and toggled r_ready, index wrap, range handling and mid-burst reset.
module tb_axi_mem_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        aw_valid = 0, aw_ready;
  logic [31:0] aw_addr = '0;
  logic [5:0]  aw_id = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_size = 3'd3;
  logic [1:0]  aw_burst = 2'd1;
  logic        w_valid = 0, w_ready;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        w_last = 0;
  logic        b_valid, b_ready = 0;
  logic [5:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid = 0, ar_ready;
  logic [31:0] ar_addr = '0;
  logic [5:0]  ar_id = '0;
  logic [7:0]  ar_len = '0;
  logic [2:0]  ar_size = 3'd3;
  logic [1:0]  ar_burst = 2'd1;
  logic        r_valid, r_ready = 0;
  logic [63:0] r_data;
  logic [5:0]  r_id;
  logic [1:0]  r_resp;
  logic        r_last;

  int nchk = 0, nfail = 0;
  logic [63:0] wdat [0:3];
  logic [7:0]  wstb [0:3];
  logic [63:0] rexp [0:3];

  always #5 clock = ~clock;

  axi_mem_responder dut (
    .clock(clock), .reset_n(reset_n),
    .io_axi_aw_valid(aw_valid), .io_axi_aw_ready(aw_ready),
    .io_axi_aw_bits_addr(aw_addr), .io_axi_aw_bits_id(aw_id), .io_axi_aw_bits_len(aw_len),
    .io_axi_aw_bits_size(aw_size), .io_axi_aw_bits_burst(aw_burst),
    .io_axi_w_valid(w_valid), .io_axi_w_ready(w_ready),
    .io_axi_w_bits_data(w_data), .io_axi_w_bits_strb(w_strb), .io_axi_w_bits_last(w_last),
    .io_axi_b_valid(b_valid), .io_axi_b_ready(b_ready),
    .io_axi_b_bits_id(b_id), .io_axi_b_bits_resp(b_resp),
    .io_axi_ar_valid(ar_valid), .io_axi_ar_ready(ar_ready),
    .io_axi_ar_bits_addr(ar_addr), .io_axi_ar_bits_id(ar_id), .io_axi_ar_bits_len(ar_len),
    .io_axi_ar_bits_size(ar_size), .io_axi_ar_bits_burst(ar_burst),
    .io_axi_r_valid(r_valid), .io_axi_r_ready(r_ready),
    .io_axi_r_bits_data(r_data), .io_axi_r_bits_id(r_id),
    .io_axi_r_bits_resp(r_resp), .io_axi_r_bits_last(r_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic aw_send(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    aw_addr = a; aw_id = id; aw_len = len; aw_valid = 1'b1;
    for (int n = 0; n < 20 && !aw_ready; n++) @(negedge clock);
    chk("aw_ready", aw_ready, 1);
    @(negedge clock);
    aw_valid = 1'b0;
  endtask

  task automatic w_send(input int beats);
    for (int i = 0; i < beats; i++) begin
      w_data = wdat[i]; w_strb = wstb[i]; w_valid = 1'b1; w_last = (i == beats - 1);
      for (int n = 0; n < 20 && !w_ready; n++) @(negedge clock);
      chk("w_ready", w_ready, 1);
      @(negedge clock);
    end
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic b_recv(input logic [5:0] id, input logic [1:0] resp);
    b_ready = 1'b1;
    for (int n = 0; n < 20 && !b_valid; n++) @(negedge clock);
    chk("b_valid", b_valid, 1);
    chk("b_id", b_id, id);
    chk("b_resp", b_resp, resp);
    @(negedge clock);
    b_ready = 1'b0;
    chk("b_valid_drop", b_valid, 0);
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    ar_addr = a; ar_id = id; ar_len = len; ar_valid = 1'b1;
    for (int n = 0; n < 20 && !ar_ready; n++) @(negedge clock);
    chk("ar_ready", ar_ready, 1);
    @(negedge clock);
    ar_valid = 1'b0;
    chk("r_valid_next_cycle", r_valid, 1);
  endtask

  task automatic r_recv(input int beats, input bit toggle, input logic [5:0] id,
                        input logic [1:0] resp);
    for (int i = 0; i < beats; i++) begin
      int w;
      w = 0;
      if (toggle) begin
        r_ready = 1'b0;
        @(negedge clock);
        chk("r_hold_valid", r_valid, 1);
        chk("r_hold_data", r_data, rexp[i]);
        chk("r_hold_last", r_last, (i == beats - 1));
      end
      r_ready = 1'b1;
      while (!r_valid && w < 20) begin @(negedge clock); w++; end
      chk("r_valid", r_valid, 1);
      if (!toggle && i > 0) chk("r_consecutive", w, 0);
      chk("r_data", r_data, rexp[i]);
      chk("r_last", r_last, (i == beats - 1));
      chk("r_id", r_id, id);
      chk("r_resp", r_resp, resp);
      @(negedge clock);
    end
    r_ready = 1'b0;
    chk("r_valid_drop", r_valid, 0);
    chk("ar_ready_back", ar_ready, 1);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_last", r_last, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_b_id", b_id, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_aw_ready", aw_ready, 1);
    chk("post_rst_ar_ready", ar_ready, 1);

    // Single-beat write and read back
    wdat[0] = 64'h1122334455667788; wstb[0] = 8'hFF;
    aw_send(32'h40, 6'd5, 8'd0); w_send(1); b_recv(6'd5, 2'b00);
    rexp[0] = 64'h1122334455667788;
    ar_send(32'h40, 6'd9, 8'd0); r_recv(1, 0, 6'd9, 2'b00);

    // Four-beat burst, read with r_ready held then toggled
    for (int i = 0; i < 4; i++) begin
      wdat[i] = {32'hA5A5_0000 + 32'(i), 32'h0F0F_0000 + 32'(i)};
      wstb[i] = 8'hFF;
      rexp[i] = wdat[i];
    end
    aw_send(32'h0, 6'd1, 8'd3); w_send(4); b_recv(6'd1, 2'b00);
    ar_send(32'h0, 6'd2, 8'd3); r_recv(4, 0, 6'd2, 2'b00);
    ar_send(32'h0, 6'd3, 8'd3); r_recv(4, 1, 6'd3, 2'b00);

    // Byte strobes: lower four bytes cleared
    wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstb[0] = 8'hFF;
    aw_send(32'h08, 6'd7, 8'd0); w_send(1); b_recv(6'd7, 2'b00);
    wdat[0] = 64'h0; wstb[0] = 8'h0F;
    aw_send(32'h08, 6'd8, 8'd0); w_send(1); b_recv(6'd8, 2'b00);
    rexp[0] = 64'hFFFF_FFFF_0000_0000;
    ar_send(32'h08, 6'd4, 8'd0); r_recv(1, 0, 6'd4, 2'b00);

    // Burst starting at the last word wraps to word 0
    wdat[0] = 64'h0123456789ABCDEF; wdat[1] = 64'hFEDCBA9876543210;
    wstb[0] = 8'hFF; wstb[1] = 8'hFF;
    aw_send(32'h7FF8, 6'd10, 8'd1); w_send(2); b_recv(6'd10, 2'b00);
    rexp[0] = 64'h0123456789ABCDEF; rexp[1] = 64'hFEDCBA9876543210;
    ar_send(32'h7FF8, 6'd11, 8'd1); r_recv(2, 0, 6'd11, 2'b00);
    rexp[0] = 64'hFEDCBA9876543210;
    ar_send(32'h0, 6'd12, 8'd0); r_recv(1, 0, 6'd12, 2'b00);

`ifdef AXI_MEM_RESP_ERR_EN
    // Out-of-window bursts complete with SLVERR and leave memory alone
    rexp[0] = 64'h0; rexp[1] = 64'h0;
    ar_send(32'h8000, 6'd13, 8'd1); r_recv(2, 0, 6'd13, 2'b10);
    wdat[0] = 64'hDEAD_BEEF_DEAD_BEEF; wstb[0] = 8'hFF;
    aw_send(32'h8000, 6'd14, 8'd0); w_send(1); b_recv(6'd14, 2'b10);
    rexp[0] = 64'hFEDCBA9876543210;
    ar_send(32'h0, 6'd15, 8'd0); r_recv(1, 0, 6'd15, 2'b00);
`else
    // Without the range check, 0x8040 aliases onto word 8 with OKAY
    wdat[0] = 64'hCAFE_F00D_1234_5678; wstb[0] = 8'hFF;
    aw_send(32'h8040, 6'd13, 8'd0); w_send(1); b_recv(6'd13, 2'b00);
    rexp[0] = 64'hCAFE_F00D_1234_5678;
    ar_send(32'h40, 6'd14, 8'd0); r_recv(1, 0, 6'd14, 2'b00);
`endif

    // Reset during beat 2 of a 4-beat write
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 64'h5500_0000_0000_0000 + 64'(i); wstb[i] = 8'hFF;
    end
    aw_send(32'h100, 6'd20, 8'd3); w_send(2);
    w_data = wdat[2]; w_strb = 8'hFF; w_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_w_ready", w_ready, 0);
    chk("mid_rst_aw_ready", aw_ready, 0);
    chk("mid_rst_ar_ready", ar_ready, 0);
    chk("mid_rst_b_valid", b_valid, 0);
    chk("mid_rst_r_valid", r_valid, 0);
    w_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_mid_rst_aw_ready", aw_ready, 1);
    chk("post_mid_rst_b_valid", b_valid, 0);
    rexp[0] = wdat[0]; rexp[1] = wdat[1];
    ar_send(32'h100, 6'd21, 8'd1); r_recv(2, 0, 6'd21, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
